muldiv_unit: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU engine and architectural HI/LO register pair.

---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with the architectural HI/LO pair.
// Multiply is a registered product; divide is a 32-step restoring divider on magnitudes.
module muldiv_unit #(
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned XLEN    = 32;
   localparam int unsigned CNT_MAX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam bit          MUL_COMB = (MUL_LAT == 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MUL   = 3'd1;
   localparam logic [2:0] S_DPREP = 3'd2;
   localparam logic [2:0] S_DITER = 3'd3;
   localparam logic [2:0] S_DFIX  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;
   logic              w_mul_wr;
   logic              w_div_wr;
   logic              w_mt_ok;

   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic              r_sgn;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;

   logic [2*XLEN-1:0] r_prod;
   logic [2*XLEN-1:0] w_ma;
   logic [2*XLEN-1:0] w_mb;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_mul_res;

   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_dvs;
   logic              r_qneg;
   logic              r_rneg;
   logic              r_div0;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;
   logic [XLEN-1:0]   w_quo_fix;
   logic [XLEN-1:0]   w_rem_fix;

   // Sign-extend to 64 bits so one unsigned multiplier serves MULT and MULTU
   assign w_ma      = {{XLEN{r_sgn & r_a[XLEN-1]}}, r_a};
   assign w_mb      = {{XLEN{r_sgn & r_b[XLEN-1]}}, r_b};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = MUL_COMB ? w_prod : r_prod;

   assign w_abs_a   = (r_sgn & r_a[XLEN-1]) ? XLEN'(-r_a) : r_a;
   assign w_abs_b   = (r_sgn & r_b[XLEN-1]) ? XLEN'(-r_b) : r_b;

   // r_quo shifts dividend bits out of the top while quotient bits enter the bottom
   assign w_shift   = {r_rem, r_quo[XLEN-1]};
   assign w_diff    = w_shift - {1'b0, r_dvs};

   assign w_quo_fix = r_div0 ? {XLEN{1'b1}} : (r_qneg ? XLEN'(-r_quo) : r_quo);
   assign w_rem_fix = r_div0 ? r_a          : (r_rneg ? XLEN'(-r_rem) : r_rem);

   assign req_ready = (r_state == S_IDLE || r_state == S_DONE) & ~cancel;
   assign busy      = r_busy;
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;

   // State register with busy/done decoded from the next state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state and control decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mul_wr    = 1'b0;
      w_div_wr    = 1'b0;
      w_mt_ok     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_mt_ok = 1'b1;
            if (req_valid && !cancel) begin
               w_accept    = 1'b1;
               w_state_nxt = op[1] ? S_DPREP : S_MUL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (cancel) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_mul_wr    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DPREP: begin
            w_state_nxt = cancel ? S_IDLE : S_DITER;
         end
         S_DITER: begin
            if (cancel) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_DFIX;
            end
         end
         S_DFIX: begin
            if (cancel) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_div_wr    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration counter and arithmetic datapath
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a    <= '0;
         r_b    <= '0;
         r_sgn  <= 1'b0;
         r_cnt  <= '0;
         r_prod <= '0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_div0 <= 1'b0;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_sgn <= ~op[0];
         r_cnt <= CNT_W'(MUL_LAT - 1);
      end else begin
         case (r_state)
            S_MUL: begin
               r_prod <= w_prod;
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            S_DPREP: begin
               r_quo  <= w_abs_a;
               r_dvs  <= w_abs_b;
               r_rem  <= '0;
               r_qneg <= r_sgn & (r_a[XLEN-1] ^ r_b[XLEN-1]);
               r_rneg <= r_sgn & r_a[XLEN-1];
               r_div0 <= (r_b == '0);
               r_cnt  <= CNT_W'(DIV_ITER - 1);
            end
            S_DITER: begin
               if (!w_diff[XLEN]) begin
                  r_rem <= w_diff[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], 1'b0};
               end
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // HI/LO: MTHI/MTLO only while not busy; op results only in MUL/DFIX, so never both
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_mul_wr) begin
         r_hi <= w_mul_res[2*XLEN-1:XLEN];
         r_lo <= w_mul_res[XLEN-1:0];
      end else if (w_div_wr) begin
         r_hi <= w_rem_fix;
         r_lo <= w_quo_fix;
      end else if (w_mt_ok) begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, arithmetic corners,
// cancel, MTHI/MTLO gating, back-to-back issue and asynchronous reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   muldiv_unit #(.MUL_LAT(2), .DIV_ITER(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .cancel    (cancel),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Present an op before the next edge; returns #1 after the accept edge with operands scrambled
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      req_valid = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      req_valid = 1'b0; op = ~o; A = 32'h5A5A_0F0F; B = 32'h0000_0000;
   endtask

   // Edges from the accept edge until done is seen (-1 on timeout)
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; req_valid = 1'b0; op = 2'b00; A = '0; B = '0;
      cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++; if (hi !== 32'h0)       begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h0)       begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
   endtask

   task automatic test_mult;
      int lat;
      start_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got=%b exp=1", busy); end
      wait_done(lat);
      checks++; if (lat != 2)             begin errors++; $display("FAIL mult_lat got=%0d exp=2", lat); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
      start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat);
      checks++; if (lat != 2)             begin errors++; $display("FAIL multu_lat got=%0d exp=2", lat); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
   endtask

   task automatic test_div;
      int lat;
      logic [1:0]  t_op [4] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
      logic [31:0] t_a  [4] = '{32'hFFFF_FFF9, 32'd7, 32'd100, 32'hFFFF_FF9C};
      logic [31:0] t_b  [4] = '{32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] t_lo [4] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFF2, 32'h0000_000E};
      logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'hFFFF_FFFE};
      for (int i = 0; i < 4; i++) begin
         start_op(t_op[i], t_a[i], t_b[i]);
         wait_done(lat);
         checks++; if (lat != 34)      begin errors++; $display("FAIL div%0d_lat got=%0d exp=34", i, lat); end
         checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, t_lo[i]); end
         checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, t_hi[i]); end
      end
   endtask

   task automatic test_div_corner;
      int lat;
      logic [1:0]  t_op [3] = '{OP_DIVU, OP_DIV, OP_DIV};
      logic [31:0] t_a  [3] = '{32'd5, 32'hFFFF_FFFB, 32'h8000_0000};
      logic [31:0] t_b  [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] t_lo [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] t_hi [3] = '{32'd5, 32'hFFFF_FFFB, 32'h0};
      for (int i = 0; i < 3; i++) begin
         start_op(t_op[i], t_a[i], t_b[i]);
         wait_done(lat);
         checks++; if (lat != 34)      begin errors++; $display("FAIL corner%0d_lat got=%0d exp=34", i, lat); end
         checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL corner%0d_lo got=%h exp=%h", i, lo, t_lo[i]); end
         checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL corner%0d_hi got=%h exp=%h", i, hi, t_hi[i]); end
      end
   endtask

   task automatic test_cancel;
      int lat;
      int seen = 0;
      // hi=0, lo=8000_0000 from the previous op
      start_op(OP_DIV, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      if (done) seen++;
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL cancel_busy got=%b exp=0", busy); end
      checks++; if (seen != 0)            begin errors++; $display("FAIL cancel_done got=%0d exp=0", seen); end
      checks++; if (hi !== 32'h0)         begin errors++; $display("FAIL cancel_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL cancel_lo got=%h exp=80000000", lo); end
      req_valid = 1'b1; op = OP_DIVU; A = 32'd7; B = 32'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_reaccept got=%b exp=1", busy); end
      wait_done(lat);
      checks++; if (lat != 34)    begin errors++; $display("FAIL cancel_next_lat got=%0d exp=34", lat); end
      checks++; if (lo !== 32'd3) begin errors++; $display("FAIL cancel_next_lo got=%h exp=3", lo); end
      // Cancel in IDLE masks the request
      @(posedge clk); #1;
      cancel = 1'b1; req_valid = 1'b1; op = OP_MULT; A = 32'd2; B = 32'd2;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cancel_idle_ready got=%b exp=0", req_ready); end
      @(posedge clk); #1;
      cancel = 1'b0; req_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_accept got=%b exp=0", busy); end
   endtask

   task automatic test_mthilo;
      int lat;
      @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1; hi_we = 1'b0;
      checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi got=%h exp=a5a5a5a5", hi); end
      checks++; if (lo !== 32'd3)         begin errors++; $display("FAIL mthi_lo_kept got=%h exp=3", lo); end
      @(negedge clk); lo_we = 1'b1; wdata = 32'h1234_5678;
      @(posedge clk); #1; lo_we = 1'b0;
      checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got=%h exp=12345678", lo); end
      @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
      @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F)
         begin errors++; $display("FAIL mt_both got=%h/%h exp=0f0f0f0f/0f0f0f0f", hi, lo); end
      // Write while busy is dropped
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (hi !== 32'h0F0F_0F0F) begin errors++; $display("FAIL mthi_busy got=%h exp=0f0f0f0f", hi); end
      wait_done(lat);
      checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL mt_busy_res got=%h/%h exp=2/e", hi, lo); end
      // Same-edge accept and MTHI: wdata lands, then the product overwrites it
      @(negedge clk);
      req_valid = 1'b1; op = OP_MULTU; A = 32'd2; B = 32'd3; hi_we = 1'b1; wdata = 32'h1111_2222;
      @(posedge clk); #1;
      req_valid = 1'b0; hi_we = 1'b0;
      checks++; if (hi !== 32'h1111_2222) begin errors++; $display("FAIL mthi_accept got=%h exp=11112222", hi); end
      wait_done(lat);
      checks++; if (hi !== 32'h0 || lo !== 32'd6) begin errors++; $display("FAIL mthi_accept_res got=%h/%h exp=0/6", hi, lo); end
   endtask

   task automatic test_back_to_back;
      int lat;
      start_op(OP_MULT, 32'h0000_0010, 32'hFFFF_FFFF);
      wait_done(lat);
      checks++; if (lo !== 32'hFFFF_FFF0 || hi !== 32'hFFFF_FFFF)
         begin errors++; $display("FAIL b2b_first got=%h/%h exp=ffffffff/fffffff0", hi, lo); end
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0)
         begin errors++; $display("FAIL b2b_done_ready got=%b/%b exp=1/0", req_ready, busy); end
      req_valid = 1'b1; op = OP_MULTU; A = 32'd3; B = 32'd5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
      wait_done(lat);
      checks++; if (lat != 2)                       begin errors++; $display("FAIL b2b_lat got=%0d exp=2", lat); end
      checks++; if (lo !== 32'd15 || hi !== 32'h0) begin errors++; $display("FAIL b2b_second got=%h/%h exp=0/f", hi, lo); end
   endtask

   task automatic test_reset_mid;
      start_op(OP_DIV, 32'd77, 32'd5);
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_state got=%b/%b exp=0/0", busy, done); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0)   begin errors++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo); end
      @(negedge clk); resetn = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) begin
            checks++; errors++; $display("FAIL rst_mid_stray_done got=1 exp=0");
         end
      end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_corner();
      test_cancel();
      test_mthilo();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
